// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in serial-out shift-register transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per clock on a registered serial line, with frame_start/done markers
// so a downstream SIPO or flip-flop chain can rebuild the word.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit
// after the data bits (frame grows to WIDTH+1 cycles).
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam int             CW           = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST_IDX     = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]  PRE_LAST_IDX = CW'(FRAME_LEN - 2);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;     // bits still waiting to be sent
  logic [CW-1:0]    cnt;       // index of the bit currently on sout
  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

`ifdef PISO_TX_PARITY_EN
  logic             par_bit;   // even parity of the accepted word
`endif

  assign last_bit   = (state == SHIFT) && (cnt == LAST_IDX);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];

  // Pick the bit to present next and the shift register after it leaves.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    shreg_shifted = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
`ifdef PISO_TX_PARITY_EN
    if (cnt == CW'(WIDTH - 1)) begin
      next_bit = par_bit;
    end
`endif
  end

  // Frame sequencer: load on accept, shift each cycle, close after the last bit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else if (accept) begin
      // Also covers back-to-back loads in the last-bit cycle: no gap.
      state       <= SHIFT;
      shreg       <= MSB_FIRST ? (din << 1) : (din >> 1);
      cnt         <= '0;
      sout        <= first_bit;
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
      done        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_bit     <= ^din;
`endif
    end else if (last_bit) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else if (state == SHIFT) begin
      shreg       <= shreg_shifted;
      cnt         <= cnt + CW'(1);
      sout        <= next_bit;
      frame_start <= 1'b0;
      done        <= (cnt == PRE_LAST_IDX);
    end
  end

endmodule
